// File: rtl/pipe_nstage_pack_if.sv
// rtl/pipe_nstage_pack_if.sv - bus bundle for the N-stage shift-and-pack pipeline
//
// Signals:
//   Data      word to shift into the pipeline (DATA_W)
//   En        shift request
//   Ld        pack-and-transfer request
//   R0        packed output register (DATA_W*DEPTH), oldest word in the LSBs
//   R0_valid  one-cycle pulse while a freshly loaded R0 is presented
//   full      pipeline holds DEPTH words
//   count     number of valid words held
//   ovf       one-cycle pulse: a shift was dropped because the pipeline was full
// Modports: master drives Data/En/Ld, slave (the pipeline) drives the rest.
interface pipe_nstage_pack_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    logic [DATA_W-1:0]          Data;
    logic                       En;
    logic                       Ld;
    logic [DATA_W*DEPTH-1:0]    R0;
    logic                       R0_valid;
    logic                       full;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       ovf;

    modport master (
        output Data, En, Ld,
        input  R0, R0_valid, full, count, ovf
    );

    modport slave (
        input  Data, En, Ld,
        output R0, R0_valid, full, count, ovf
    );
endinterface

// File: rtl/pipe_nstage_pack.sv
// rtl/pipe_nstage_pack.sv - DEPTH-stage word pipeline packed into one wide output register
//
// Ports:
//   clock  rising-edge clock
//   rst    synchronous active-high reset
//   bus    pipe_nstage_pack_if.slave (Data/En/Ld in; R0/R0_valid/full/count/ovf out)
//
// Words enter at the top stage P[DEPTH-1] and move toward P[0], so after
// DEPTH shifts the oldest word sits in P[0] and lands in R0[DATA_W-1:0].
// The stages are kept as one packed vector with P[i] at bits [i*DATA_W +: DATA_W],
// which makes a load a straight copy.
module pipe_nstage_pack #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              rst,
    pipe_nstage_pack_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DATA_W * DEPTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PW-1:0]     pipe_q, pipe_d;
    logic [PW-1:0]     r0_q, r0_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              r0_valid_q, r0_valid_d;
    logic              ovf_q, ovf_d;

    logic [PW-1:0]     shifted;
    logic [PW-1:0]     reload;
    logic [CW-1:0]     count_inc;

    // New word at the top, every other stage moves down one slot.
    assign shifted   = {bus.Data, pipe_q[PW-1:DATA_W]};
    // Load and shift in the same cycle: only the incoming word survives.
    assign reload    = {bus.Data, {(PW-DATA_W){1'b0}}};
    assign count_inc = count_q + ONE_C;

    always_comb begin
        state_d    = state_q;
        pipe_d     = pipe_q;
        r0_d       = r0_q;
        count_d    = count_q;
        r0_valid_d = 1'b0;
        ovf_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.En) begin
                    pipe_d  = shifted;
                    count_d = ONE_C;
                    state_d = S_FILL;
                end else begin
                    pipe_d  = '0;
                end
            end
            S_FILL: begin
                if (bus.En) begin
                    pipe_d  = shifted;
                    count_d = count_inc;
                    if (count_inc == DEPTH_C) begin
                        state_d = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (bus.Ld) begin
                    r0_d       = pipe_q;
                    r0_valid_d = 1'b1;
                    if (bus.En) begin
                        pipe_d  = reload;
                        count_d = ONE_C;
                        state_d = S_FILL;
                    end else begin
                        pipe_d  = '0;
                        count_d = '0;
                        state_d = S_IDLE;
                    end
                end else if (bus.En) begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                pipe_d  = '0;
                count_d = '0;
                state_d = S_IDLE;
            end
        endcase

        full_d = (state_d == S_FULL);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pipe_q     <= '0;
            r0_q       <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            r0_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pipe_q     <= pipe_d;
            r0_q       <= r0_d;
            count_q    <= count_d;
            full_q     <= full_d;
            r0_valid_q <= r0_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.R0       = r0_q;
    assign bus.R0_valid = r0_valid_q;
    assign bus.full     = full_q;
    assign bus.count    = count_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_pipe_nstage_pack.sv
// tb/tb_pipe_nstage_pack.sv - directed bench for pipe_nstage_pack at DEPTH=2 and DEPTH=4
module tb_pipe_nstage_pack;
    logic clock = 1'b0;
    logic rst   = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    pipe_nstage_pack_if #(.DATA_W(8), .DEPTH(2)) if2 ();
    pipe_nstage_pack_if #(.DATA_W(8), .DEPTH(4)) if4 ();

    pipe_nstage_pack #(.DATA_W(8), .DEPTH(2)) u_d2 (
        .clock (clock),
        .rst   (rst),
        .bus   (if2.slave)
    );

    pipe_nstage_pack #(.DATA_W(8), .DEPTH(4)) u_d4 (
        .clock (clock),
        .rst   (rst),
        .bus   (if4.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push4(input logic [7:0] d);
        if4.En   = 1'b1;
        if4.Data = d;
        tick();
        if4.En   = 1'b0;
    endtask

    task automatic chk4(input string tag, input logic [31:0] r0, input logic vld,
                        input logic [2:0] cnt, input logic fl, input logic ov);
        chk({tag, ".R0"},       64'(if4.R0),       64'(r0));
        chk({tag, ".R0_valid"}, 64'(if4.R0_valid), 64'(vld));
        chk({tag, ".count"},    64'(if4.count),    64'(cnt));
        chk({tag, ".full"},     64'(if4.full),     64'(fl));
        chk({tag, ".ovf"},      64'(if4.ovf),      64'(ov));
    endtask

    initial begin
        if2.Data = '0; if2.En = 1'b0; if2.Ld = 1'b0;
        if4.Data = '0; if4.En = 1'b1; if4.Ld = 1'b1;

        // reset overrides En/Ld
        rst = 1'b1;
        tick(); tick();
        if4.En = 1'b0; if4.Ld = 1'b0;
        chk4("reset", 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("reset2.R0",    64'(if2.R0),       64'h0);
        chk("reset2.count", 64'(if2.count),    64'h0);
        chk("reset2.valid", 64'(if2.R0_valid), 64'h0);
        rst = 1'b0;

        // DEPTH=2 basic fill and load
        if2.En = 1'b1; if2.Data = 8'h55;
        tick();
        chk("d2.fill1.count", 64'(if2.count), 64'd1);
        chk("d2.fill1.full",  64'(if2.full),  64'd0);
        if2.Data = 8'h56;
        tick();
        chk("d2.fill2.count", 64'(if2.count), 64'd2);
        chk("d2.fill2.full",  64'(if2.full),  64'd1);
        if2.En = 1'b0; if2.Ld = 1'b1;
        tick();
        if2.Ld = 1'b0;
        chk("d2.load.R0",    64'(if2.R0),       64'h5655);
        chk("d2.load.valid", 64'(if2.R0_valid), 64'd1);
        chk("d2.load.count", 64'(if2.count),    64'd0);
        chk("d2.load.full",  64'(if2.full),     64'd0);
        tick();
        chk("d2.after.valid", 64'(if2.R0_valid), 64'd0);
        chk("d2.after.R0",    64'(if2.R0),       64'h5655);

        // DEPTH=4 fill with a stall
        push4(8'h11);
        push4(8'h22);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk4("d4.stall", 32'h0, 1'b0, 3'd2, 1'b0, 1'b0);
        end
        push4(8'h33);
        chk4("d4.fill3", 32'h0, 1'b0, 3'd3, 1'b0, 1'b0);
        push4(8'h44);
        chk4("d4.fill4", 32'h0, 1'b0, 3'd4, 1'b1, 1'b0);
        if4.Ld = 1'b1;
        tick();
        if4.Ld = 1'b0;
        chk4("d4.load", 32'h44332211, 1'b1, 3'd0, 1'b0, 1'b0);

        // Ld ignored in S_IDLE and S_FILL
        if4.Ld = 1'b1;
        tick();
        if4.Ld = 1'b0;
        chk4("d4.ld_idle", 32'h44332211, 1'b0, 3'd0, 1'b0, 1'b0);
        push4(8'h01);
        push4(8'h02);
        push4(8'h03);
        if4.Ld = 1'b1;
        tick();
        if4.Ld = 1'b0;
        chk4("d4.ld_fill", 32'h44332211, 1'b0, 3'd3, 1'b0, 1'b0);

        // reset mid-fill at count=3, with En asserted
        rst = 1'b1; if4.En = 1'b1; if4.Data = 8'h99;
        tick();
        rst = 1'b0; if4.En = 1'b0;
        chk4("d4.rst_fill", 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);

        // overflow while full, then load
        push4(8'hA0); push4(8'hA1); push4(8'hA2); push4(8'hA3);
        chk4("d4.fullA", 32'h0, 1'b0, 3'd4, 1'b1, 1'b0);
        push4(8'hFF);
        chk4("d4.ovf", 32'h0, 1'b0, 3'd4, 1'b1, 1'b1);
        tick();
        chk4("d4.ovf_end", 32'h0, 1'b0, 3'd4, 1'b1, 1'b0);
        if4.Ld = 1'b1;
        tick();
        if4.Ld = 1'b0;
        chk4("d4.loadA", 32'hA3A2A1A0, 1'b1, 3'd0, 1'b0, 1'b0);

        // simultaneous Ld and En while full
        push4(8'hC0); push4(8'hC1); push4(8'hC2); push4(8'hC3);
        if4.Ld = 1'b1; if4.En = 1'b1; if4.Data = 8'hB0;
        tick();
        if4.Ld = 1'b0; if4.En = 1'b0;
        chk4("d4.ld_en", 32'hC3C2C1C0, 1'b1, 3'd1, 1'b0, 1'b0);
        tick();
        chk4("d4.ld_en_hold", 32'hC3C2C1C0, 1'b0, 3'd1, 1'b0, 1'b0);
        push4(8'hD1); push4(8'hD2); push4(8'hD3);
        chk4("d4.refull", 32'hC3C2C1C0, 1'b0, 3'd4, 1'b1, 1'b0);
        if4.Ld = 1'b1;
        tick();
        if4.Ld = 1'b0;
        chk4("d4.loadB", 32'hD3D2D1B0, 1'b1, 3'd0, 1'b0, 1'b0);

        // reset in S_FULL with Ld asserted
        push4(8'hE0); push4(8'hE1); push4(8'hE2); push4(8'hE3);
        rst = 1'b1; if4.Ld = 1'b1;
        tick();
        rst = 1'b0; if4.Ld = 1'b0;
        chk4("d4.rst_full", 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        chk4("d4.rst_full2", 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);

        // first En after reset
        push4(8'h77);
        chk4("d4.post_rst", 32'h0, 1'b0, 3'd1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_nstage_pack.md
PIPE_NSTAGE_PACK -- requirements
Module: pipe_nstage_pack

Interface
REQ-001 Parameter DATA_W, default 8: width of each input word, in bits.
REQ-002 Parameter DEPTH, default 4: number of pipeline stages and words per packed output; legal range 2..16.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 Data  input  DATA_W  input word, sampled on the rising edge when it is accepted.
REQ-006 En  input  1  request to shift Data into the pipeline.
REQ-007 Ld  input  1  request to transfer the full pipeline into R0.
REQ-008 R0  output  DATA_W*DEPTH  packed output register.
REQ-009 R0_valid  output  1  one-cycle pulse, high in the cycle after R0 is updated.
REQ-010 full  output  1  high when count == DEPTH.
REQ-011 count  output  $clog2(DEPTH+1)  number of valid words currently held.
REQ-012 ovf  output  1  one-cycle pulse: En was dropped because the pipeline was full.

Function
REQ-013 Stages P[0..DEPTH-1]: an accepted shift SHALL do P[DEPTH-1] <= Data and P[i] <= P[i+1] for every i < DEPTH-1.
REQ-014 A load SHALL pack R0 = {P[DEPTH-1], ..., P[1], P[0]}, i.e. the oldest word occupies R0[DATA_W-1:0].
REQ-015 The FSM SHALL have exactly three states: S_IDLE (count=0), S_FILL (0<count<DEPTH), S_FULL (count=DEPTH).
REQ-016 S_IDLE: En=1 -> shift, count=1, next state S_FILL. En=0 -> hold all stages at zero, stay in S_IDLE.
REQ-017 S_FILL: En=1 -> shift, count+1, next state S_FULL when the new count is DEPTH, otherwise stay in S_FILL.
REQ-018 S_FILL: En=0 -> hold stages and count, stay in S_FILL (stall).
REQ-019 Ld while in S_IDLE or S_FILL SHALL be ignored: R0 unchanged, no R0_valid pulse.
REQ-020 S_FULL with Ld=1 and En=0: load R0, clear all stages to 0, count=0, next state S_IDLE.
REQ-021 S_FULL with Ld=1 and En=1 in the same cycle: load R0 from the pre-edge stages, then P[DEPTH-1] <= Data and all other stages <= 0, count=1, next state S_FILL; no word is lost.
REQ-022 S_FULL with Ld=0 and En=1: Data dropped, stages unchanged, ovf pulses high for one cycle.
REQ-023 S_FULL with Ld=0 and En=0: hold, indefinitely if need be.
REQ-024 R0 SHALL change only on a load, and SHALL hold its value at all other times.
REQ-025 Load latency: R0 is valid at the first rising edge after Ld is sampled in S_FULL; R0_valid is high for exactly that following cycle.
REQ-026 full and count SHALL be registered, consistent with the state, and free of glitches.
REQ-027 The FSM SHALL have a default transition to S_IDLE from any unused state encoding.

Reset
REQ-028 rst=1 at a rising edge SHALL set: state S_IDLE, every stage 0, R0 0, count 0, full 0, R0_valid 0, ovf 0.
REQ-029 rst SHALL override En and Ld in the same cycle, including when asserted mid-fill or while in S_FULL.
REQ-030 The first En accepted after rst deasserts SHALL behave as REQ-016.

Verification
REQ-031 DEPTH=2, DATA_W=8: rst, then En=1 for two cycles with Data 8'h55 then 8'h56, then Ld=1 -> full=1 after the second edge; R0=16'h5655 and R0_valid pulses one cycle later; count=0.
REQ-032 DEPTH=4: En=1 with 8'h11 and 8'h22, En=0 for 3 cycles, En=1 with 8'h33 and 8'h44, then Ld -> count holds at 2 during the stall; R0=32'h44332211.
REQ-033 DEPTH=4, pipeline full with 8'hA0..8'hA3, En=1 with Ld=0 and Data=8'hFF -> ovf pulses once; a following Ld gives R0=32'hA3A2A1A0.
REQ-034 DEPTH=4, pipeline full, Ld=1 and En=1 in the same cycle with Data=8'hB0 -> R0 gets the old packed word; count=1, P[3]=8'hB0, state S_FILL.
REQ-035 DEPTH=4: rst asserted at count=3, and separately in S_FULL with Ld=1 -> all outputs 0, R0 unchanged from 0, no R0_valid pulse.
REQ-036 Ld pulses while in S_IDLE and while in S_FILL -> R0 unchanged and R0_valid stays 0.
